axi_ram_slave: RTL and testbench
================================

Name: axi_ram_slave

Overview:
- AXI3-style memory slave that sits directly downstream of the SoC top's AXI master port and services the cache's refill, writeback and uncached traffic.
- Backing store is a word-addressed on-chip RAM.
- Read and write channels run independent FSMs, so reads and writes can be in flight at the same time.
- Used as the memory model in system simulation and as on-chip RAM on FPGA.

Parameters:
- ADDR_WIDTH, 16: log2 of RAM depth in 32-bit words. Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses alias.
- ID_WIDTH, 4: AXI ID width.

Ports:
- aclk  input  1  clock
- aresetn  input  1  synchronous active-low reset
- arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/32/8/3/2  read address channel fields
- arlock/arcache/arprot  input  2/4/3  accepted and ignored
- arvalid  input  1 / arready  output  1  read address handshake
- rid/rdata/rresp/rlast  output  ID_WIDTH/32/2/1  read data channel
- rvalid  output  1 / rready  input  1  read data handshake
- awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/32/8/3/2  write address channel fields
- awlock/awcache/awprot  input  2/4/3  ignored
- awvalid  input  1 / awready  output  1  write address handshake
- wid/wdata/wstrb/wlast  input  ID_WIDTH/32/4/1  write data channel; wid and wlast are ignored
- wvalid  input  1 / wready  output  1  write data handshake
- bid/bresp  output  ID_WIDTH/2  write response
- bvalid  output  1 / bready  input  1  write response handshake

Behaviour:
- Reset (aresetn=0 sampled at posedge):
  - Both FSMs go to IDLE.
  - arready=1, awready=1.
  - rvalid=0, wready=0, bvalid=0, rlast=0, rdata=0, rid=0, bid=0.
  - rresp and bresp are constant 2'b00 (OKAY).
  - RAM contents are NOT cleared.
  - Reset mid-burst abandons the burst; no further beats or responses are issued.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, latch id, len, size and burst. Load rdata<=mem[araddr word], set rvalid=1, beat counter=0, next address = araddr+step. Go to R_DATA.
  - First beat is valid the cycle after the AR handshake (latency 1).
  - R_DATA: arready=0. rlast=(beat==len).
  - On rvalid&&rready with !rlast: load rdata from the next address, beat+1, advance address.
  - On rvalid&&rready with rlast: rvalid=0, rlast=0, return to R_IDLE. arready is 1 the following cycle; there are no back-to-back AR accepts.
  - rvalid && !rready: rdata, rlast and rid hold stable.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: awready=1. On handshake, latch id, addr, len, size and burst; beat=0; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready, write byte lane i of the current word iff wstrb[i]. Then beat+1 and advance address.
  - On the beat where beat==len, go to W_RESP. wlast is not checked; the burst length comes only from awlen.
  - W_RESP: wready=0, bvalid=1, bid=latched id. On bready, go to W_IDLE.
- Address step:
  - arburst/awburst 2'b00 (FIXED): step 0.
  - 2'b01 (INCR), and 2'b10/2'b11 (treated as INCR): step = 1<<size.
  - size>2 is clamped to 4.
- Sub-word reads return the full 32-bit word; the master selects the lanes.
- Word index wraps modulo RAM depth; a burst crossing the top wraps to word 0.
- Read/write collision in the same cycle on the same word: the read is read-first and returns the old data. The write commits at that edge.
- Read and write FSMs never stall each other.
- len=0: single beat; rlast is asserted on the first rvalid.

Test Plan:
- Write mem[0x10]=0xDEADBEEF through a single-beat AW/W with wstrb=4'hF, bready=1 → bvalid one cycle after the W handshake, bid=awid=4'h3. Then read araddr=0x40, arlen=0 → rvalid one cycle after AR with rdata=0xDEADBEEF, rlast=1, rid=arid.
- 8-beat INCR read from 0x100 of preloaded words k+1, with rready toggling 1,0,1,... → data sequence 1..8 in order, each beat held while rready=0, rlast only on beat 8, arready=0 until after the last handshake.
- Preload 0x11223344 at 0x200, write 0xAABBCCDD with wstrb=4'b0101 → read-back gives 0x11BB33DD.
- FIXED write burst awlen=3 to 0x300 with data 1,2,3,4 → exactly 4 W handshakes, then a single B; mem[0x300]=4.
- AR and AW handshake in the same cycle to the same word (old=0x5, new=0x9) → read returns 0x5; a subsequent read returns 0x9; both channels complete with no stall.
- Assert aresetn=0 for one cycle at beat 3 of an 8-beat read and at beat 2 of a write → next cycle rvalid=0, bvalid=0, wready=0, arready=1, awready=1; beats already written persist; a new read completes normally.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI3 memory slave backed by a word-addressed on-chip RAM.
// Separate read and write burst engines share the array, so both directions can be in flight at once.
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic [1:0]          arlock,
    input  logic [3:0]          arcache,
    input  logic [2:0]          arprot,
    input  logic                arvalid,
    output logic                arready,

    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,

    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [1:0]          awlock,
    input  logic [3:0]          awcache,
    input  logic [2:0]          awprot,
    input  logic                awvalid,
    output logic                awready,

    input  logic [ID_WIDTH-1:0] wid,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,

    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rdState_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wrState_t;

    logic [31:0] mem [DEPTH];

    // FIXED bursts stay put; everything else increments, with sizes above a word clamped to 4 bytes.
    function automatic logic [31:0] addrStep(input logic [1:0] burst, input logic [2:0] size);
        if (burst == 2'b00) begin
            return 32'd0;
        end else if (size > 3'd2) begin
            return 32'd4;
        end else begin
            return 32'd1 << size;
        end
    endfunction

    rdState_t              rdState_q, rdState_d;
    logic [ID_WIDTH-1:0]   rdId_q, rdId_d;
    logic [7:0]            rdLen_q, rdLen_d;
    logic [2:0]            rdSize_q, rdSize_d;
    logic [1:0]            rdBurst_q, rdBurst_d;
    logic [7:0]            rdBeat_q, rdBeat_d;
    logic [31:0]           rdAddr_q, rdAddr_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           rdata_q;
    logic                  rdLoad;
    logic [ADDR_WIDTH-1:0] rdLoadIdx;

    wrState_t              wrState_q, wrState_d;
    logic [ID_WIDTH-1:0]   wrId_q, wrId_d;
    logic [7:0]            wrLen_q, wrLen_d;
    logic [2:0]            wrSize_q, wrSize_d;
    logic [1:0]            wrBurst_q, wrBurst_d;
    logic [7:0]            wrBeat_q, wrBeat_d;
    logic [31:0]           wrAddr_q, wrAddr_d;
    logic                  wrEn;

    logic                  unusedSigs;

    assign unusedSigs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast};

    always_comb begin
        rdState_d = rdState_q;
        rdId_d    = rdId_q;
        rdLen_d   = rdLen_q;
        rdSize_d  = rdSize_q;
        rdBurst_d = rdBurst_q;
        rdBeat_d  = rdBeat_q;
        rdAddr_d  = rdAddr_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdLoad    = 1'b0;
        rdLoadIdx = rdAddr_q[ADDR_WIDTH+1:2];
        arready   = 1'b0;

        unique case (rdState_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rdId_d    = arid;
                    rdLen_d   = arlen;
                    rdSize_d  = arsize;
                    rdBurst_d = arburst;
                    rdLoad    = 1'b1;
                    rdLoadIdx = araddr[ADDR_WIDTH+1:2];
                    rdAddr_d  = araddr + addrStep(arburst, arsize);
                    rdBeat_d  = 8'd0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (arlen == 8'd0);
                    rdState_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdState_d = R_IDLE;
                    end else begin
                        rdLoad   = 1'b1;
                        rdAddr_d = rdAddr_q + addrStep(rdBurst_q, rdSize_q);
                        rdBeat_d = rdBeat_q + 8'd1;
                        rlast_d  = ((rdBeat_q + 8'd1) == rdLen_q);
                    end
                end
            end
            default: begin
                rdState_d = R_IDLE;
            end
        endcase
    end

    // rdata is loaded straight from the array, so a same-edge write is seen only on the next load.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rdState_q <= R_IDLE;
            rdId_q    <= '0;
            rdLen_q   <= '0;
            rdSize_q  <= '0;
            rdBurst_q <= '0;
            rdBeat_q  <= '0;
            rdAddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rdState_q <= rdState_d;
            rdId_q    <= rdId_d;
            rdLen_q   <= rdLen_d;
            rdSize_q  <= rdSize_d;
            rdBurst_q <= rdBurst_d;
            rdBeat_q  <= rdBeat_d;
            rdAddr_q  <= rdAddr_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            if (rdLoad) begin
                rdata_q <= mem[rdLoadIdx];
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rdata  = rdata_q;
    assign rid    = rdId_q;
    assign rresp  = 2'b00;

    always_comb begin
        wrState_d = wrState_q;
        wrId_d    = wrId_q;
        wrLen_d   = wrLen_q;
        wrSize_d  = wrSize_q;
        wrBurst_d = wrBurst_q;
        wrBeat_d  = wrBeat_q;
        wrAddr_d  = wrAddr_q;
        wrEn      = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;

        unique case (wrState_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    wrId_d    = awid;
                    wrLen_d   = awlen;
                    wrSize_d  = awsize;
                    wrBurst_d = awburst;
                    wrAddr_d  = awaddr;
                    wrBeat_d  = 8'd0;
                    wrState_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    wrEn     = 1'b1;
                    wrAddr_d = wrAddr_q + addrStep(wrBurst_q, wrSize_q);
                    wrBeat_d = wrBeat_q + 8'd1;
                    // Burst length is taken from awlen alone; wlast is not trusted.
                    if (wrBeat_q == wrLen_q) begin
                        wrState_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wrState_d = W_IDLE;
                end
            end
            default: begin
                wrState_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wrState_q <= W_IDLE;
            wrId_q    <= '0;
            wrLen_q   <= '0;
            wrSize_q  <= '0;
            wrBurst_q <= '0;
            wrBeat_q  <= '0;
            wrAddr_q  <= '0;
        end else begin
            wrState_q <= wrState_d;
            wrId_q    <= wrId_d;
            wrLen_q   <= wrLen_d;
            wrSize_q  <= wrSize_d;
            wrBurst_q <= wrBurst_d;
            wrBeat_q  <= wrBeat_d;
            wrAddr_q  <= wrAddr_d;
        end
    end

    // The array itself is never reset; a beat arriving during reset is dropped.
    always_ff @(posedge aclk) begin
        if (wrEn && aresetn) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[wrAddr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign bid   = wrId_q;
    assign bresp = 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: expected read beats and write responses are
// queued from a byte-lane memory model when stimulus is issued and retired by monitors.
module tb_axi_ram_slave;

    localparam int AW = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 aclk = ~aclk;

    axi_ram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } rBeat_t;

    rBeat_t     rExp[$];
    logic [3:0] bExp[$];
    bit [31:0]  model [int];
    int         checkCount = 0;
    int         failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int modelIdx(input logic [31:0] addr);
        return int'((addr >> 2) % (32'd1 << AW));
    endfunction

    function automatic logic [31:0] tbStep(input logic [1:0] burst, input logic [2:0] size);
        if (burst == 2'b00) return 32'd0;
        case (size)
            3'd0:    return 32'd1;
            3'd1:    return 32'd2;
            default: return 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        idx = modelIdx(addr);
        return model.exists(idx) ? model[idx] : 32'd0;
    endfunction

    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit [31:0] w;
        int idx;
        idx = modelIdx(addr);
        w = model.exists(idx) ? model[idx] : 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
        end
        model[idx] = w;
    endfunction

    // Every cycle rvalid is up, the beat on the bus must match the oldest outstanding expectation.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && rvalid === 1'b1) begin
            checkOutput("r_queue_nonempty", rExp.size() != 0, 1);
            if (rExp.size() != 0) begin
                checkOutput(rready ? "r_data" : "r_stall_data", rdata, rExp[0].data);
                checkOutput(rready ? "r_last" : "r_stall_last", rlast, rExp[0].last);
                checkOutput(rready ? "r_id" : "r_stall_id", rid, rExp[0].id);
                checkOutput("r_resp", rresp, 0);
                if (rready) void'(rExp.pop_front());
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && bvalid === 1'b1 && bready === 1'b1) begin
            checkOutput("b_queue_nonempty", bExp.size() != 0, 1);
            if (bExp.size() != 0) begin
                checkOutput("b_id", bid, bExp[0]);
                checkOutput("b_resp", bresp, 0);
                void'(bExp.pop_front());
            end
        end
    end

    task automatic applyReset(input int cycles);
        aresetn = 1'b0;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rready  = 1'b0;
        rExp.delete();
        bExp.delete();
        repeat (cycles) begin
            @(posedge aclk);
            #1;
        end
        aresetn = 1'b1;
        checkOutput("rst_arready", arready, 1);
        checkOutput("rst_awready", awready, 1);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rid", rid, 0);
        checkOutput("rst_bid", bid, 0);
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [2:0] size, input logic [3:0] id, input logic [31:0] base,
                              input logic [3:0] strb, input int abortAfter);
        logic [31:0] a;
        bit          hs;
        int          waitCnt;
        a = addr;
        bExp.push_back(id);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        waitCnt = 0;
        do begin
            hs = (awready === 1'b1);
            @(posedge aclk);
            #1;
            waitCnt++;
        end while (!hs && waitCnt < 50);
        awvalid = 1'b0;
        if (!hs) begin
            checkOutput("aw_timeout", hs, 1);
            return;
        end
        for (int k = 0; k <= int'(len); k++) begin
            if (k == abortAfter) begin
                wvalid = 1'b0;
                return;
            end
            wdata = base + k; wstrb = strb; wid = id; wlast = (k == int'(len));
            wvalid = 1'b1;
            waitCnt = 0;
            do begin
                hs = (wready === 1'b1);
                @(posedge aclk);
                #1;
                waitCnt++;
            end while (!hs && waitCnt < 50);
            if (!hs) begin
                checkOutput("w_timeout", hs, 1);
                wvalid = 1'b0;
                return;
            end
            modelWrite(a, base + k, strb);
            a = a + tbStep(burst, size);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        checkOutput("w_closed", wready, 0);
        checkOutput("b_latency", bvalid, 1);
        waitCnt = 0;
        do begin
            hs = (bvalid === 1'b1) && (bready === 1'b1);
            @(posedge aclk);
            #1;
            waitCnt++;
        end while (!hs && waitCnt < 50);
        if (!hs) checkOutput("b_timeout", hs, 1);
        checkOutput("b_cleared", bvalid, 0);
        checkOutput("aw_ready_again", awready, 1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input bit toggle,
                             input int delayCycles, input int abortAfter);
        logic [31:0] a;
        rBeat_t      beat;
        bit          hs;
        int          waitCnt;
        int          got;
        int          cyc;
        repeat (delayCycles) begin
            @(posedge aclk);
            #1;
        end
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            beat.data = modelRead(a);
            beat.last = (k == int'(len));
            beat.id   = id;
            rExp.push_back(beat);
            a = a + tbStep(burst, size);
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        waitCnt = 0;
        do begin
            hs = (arready === 1'b1);
            @(posedge aclk);
            #1;
            waitCnt++;
        end while (!hs && waitCnt < 50);
        arvalid = 1'b0;
        if (!hs) begin
            checkOutput("ar_timeout", hs, 1);
            return;
        end
        checkOutput("r_latency", rvalid, 1);
        got = 0;
        cyc = 0;
        while (got <= int'(len) && cyc < 200) begin
            if (got == abortAfter) begin
                rready = 1'b0;
                return;
            end
            rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            hs = (rvalid === 1'b1) && rready;
            checkOutput("ar_blocked", arready, 0);
            @(posedge aclk);
            #1;
            cyc++;
            if (hs) got++;
        end
        rready = 1'b0;
        checkOutput("r_beats", got, int'(len) + 1);
        checkOutput("r_done_rvalid", rvalid, 0);
        checkOutput("ar_ready_again", arready, 1);
    endtask

    task automatic applyStimulus();
        // Single-beat write then read of word 0x10.
        writeBurst(32'h40, 8'd0, 2'b01, 3'd2, 4'h3, 32'hDEADBEEF, 4'hF, -1);
        readBurst(32'h40, 8'd0, 2'b01, 3'd2, 4'h5, 1'b0, 0, -1);

        // Preload 1..8 with a write burst, then read it back with rready toggling.
        writeBurst(32'h100, 8'd7, 2'b01, 3'd2, 4'h1, 32'd1, 4'hF, -1);
        readBurst(32'h100, 8'd7, 2'b01, 3'd2, 4'hA, 1'b1, 0, -1);

        // Byte strobes.
        writeBurst(32'h200, 8'd0, 2'b01, 3'd2, 4'h2, 32'h11223344, 4'hF, -1);
        writeBurst(32'h200, 8'd0, 2'b01, 3'd2, 4'h2, 32'hAABBCCDD, 4'b0101, -1);
        readBurst(32'h200, 8'd0, 2'b01, 3'd2, 4'hB, 1'b0, 0, -1);

        // FIXED write burst lands every beat on one word.
        writeBurst(32'h300, 8'd3, 2'b00, 3'd2, 4'h4, 32'd1, 4'hF, -1);
        readBurst(32'h300, 8'd0, 2'b01, 3'd2, 4'hC, 1'b0, 0, -1);
        readBurst(32'h304, 8'd0, 2'b01, 3'd2, 4'hC, 1'b0, 0, -1);

        // Concurrent read and write to the same word: AR with AW, then AR with the W beat.
        writeBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h6, 32'h5, 4'hF, -1);
        fork
            writeBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h7, 32'h9, 4'hF, -1);
            readBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h8, 1'b0, 0, -1);
        join
        readBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h8, 1'b0, 0, -1);
        fork
            writeBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h7, 32'hC, 4'hF, -1);
            readBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h9, 1'b0, 1, -1);
        join
        readBurst(32'h600, 8'd0, 2'b01, 3'd2, 4'h9, 1'b0, 0, -1);

        // Wrap at the top of the array and address aliasing.
        writeBurst(32'h3FFFC, 8'd1, 2'b01, 3'd2, 4'h9, 32'h5000, 4'hF, -1);
        readBurst(32'h0, 8'd0, 2'b01, 3'd2, 4'h1, 1'b0, 0, -1);
        readBurst(32'h3FFFC, 8'd1, 2'b01, 3'd2, 4'h2, 1'b0, 0, -1);
        readBurst(32'h40040, 8'd0, 2'b01, 3'd2, 4'h3, 1'b0, 0, -1);

        // Narrow, oversize-clamped and reserved-burst reads.
        readBurst(32'h100, 8'd3, 2'b01, 3'd1, 4'h4, 1'b0, 0, -1);
        readBurst(32'h100, 8'd2, 2'b01, 3'd5, 4'h5, 1'b0, 0, -1);
        readBurst(32'h100, 8'd1, 2'b10, 3'd2, 4'h6, 1'b1, 0, -1);

        // Reset in the middle of a read and a write burst.
        writeBurst(32'h400, 8'd3, 2'b01, 3'd2, 4'h1, 32'h1000, 4'hF, -1);
        fork
            readBurst(32'h100, 8'd7, 2'b01, 3'd2, 4'h3, 1'b0, 0, 3);
            writeBurst(32'h400, 8'd3, 2'b01, 3'd2, 4'h2, 32'h70, 4'hF, 2);
        join
        applyReset(1);
        readBurst(32'h400, 8'd3, 2'b01, 3'd2, 4'hE, 1'b0, 0, -1);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1;

        applyReset(3);
        applyStimulus();

        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        checkOutput("r_queue_drained", rExp.size(), 0);
        checkOutput("b_queue_drained", bExp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
